qbert_hop_engine: RTL and testbench
===================================

QBERT_HOP_ENGINE -- requirements
Module: qbert_hop_engine

Interface
REQ-001 SHALL have parameter XW, default 11, x coordinate width.
REQ-002 SHALL have parameter YW, default 10, y coordinate width.
REQ-003 SHALL have parameter STEP, default 1, pixels moved per tick.
REQ-004 SHALL have parameter TICK_LOG2, default 20, giving a tick period of 2^TICK_LOG2 clk cycles.
REQ-005 SHALL have parameters XDIAG (default 60) and YDIAG (default 100), sprite extents in pixels.
REQ-006 SHALL have port clk, input, 1 bit, single clock, all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, asynchronous, active-high.
REQ-008 SHALL have ports x0/x1, inputs, XW bits, hop start x and target x.
REQ-009 SHALL have ports y0/y1, inputs, YW bits, hop start y and target y.
REQ-010 SHALL have ports x_cnt and y_cnt, inputs, XW and YW bits, current raster pixel.
REQ-011 SHALL have port qbert_jump, input, 1 bit, one-cycle hop request pulse.
REQ-012 SHALL have ports qbert_x and qbert_y, outputs, XW and YW bits, sprite centre.
REQ-013 SHALL have port busy, output, 1 bit, high while a hop is in progress.
REQ-014 SHALL have port done, output, 1 bit, one-cycle pulse when a hop completes.
REQ-015 SHALL have port le_qbert, output, 6 bits, zone hits ordered {pied_gauche, jambe_gauche, pied_droit, jambe_droite, tete, museau}.

Function
REQ-016 SHALL run a free-running TICK_LOG2-bit counter; a tick is the cycle in which the counter wraps to 0.
REQ-017 SHALL implement the states IDLE, AXIS1, AXIS2 and LAND.
REQ-018 In IDLE, position SHALL track (x0,y0) every cycle, and busy SHALL be 0.
REQ-019 On IDLE with qbert_jump=1, SHALL latch x0,y0,x1,y1, load the position with (x0,y0), set busy, and enter AXIS1.
REQ-020 Axis order SHALL be: if x1>x0 (unsigned), AXIS1 moves y and AXIS2 moves x; otherwise AXIS1 moves x and AXIS2 moves y.
REQ-021 On each tick within an axis state, the active coordinate SHALL move toward its latched target by min(STEP, |remaining|), with no overshoot.
REQ-022 When the active coordinate equals its target, the state SHALL advance on the next cycle (AXIS1->AXIS2->LAND), consuming no tick.
REQ-023 LAND SHALL last exactly one cycle, assert done, and then enter IDLE; busy SHALL be low in the cycle after LAND.
REQ-024 qbert_jump SHALL be ignored outside IDLE; a pulse arriving in the same cycle as LAND is dropped.
REQ-025 A hop whose start equals its target SHALL pass AXIS1, AXIS2 and LAND on consecutive cycles, giving done 3 cycles after accept.
REQ-026 Coordinate arithmetic SHALL use signed differences one bit wider than the coordinate, so that wrap-around cannot occur for any in-range input.
REQ-027 The le_qbert zones SHALL use du=x_cnt-qbert_x and dv=y_cnt-qbert_y (signed), with integer division, as follows:
- pied_gauche: dv in [YDIAG/6, YDIAG/2], du in [XDIAG/2, 2*XDIAG/3]
- pied_droit: dv in [-YDIAG/6, YDIAG/6), du in [XDIAG/2, 2*XDIAG/3]
- jambe_droite: dv in [-YDIAG/6, -YDIAG/12], du in [XDIAG/3, 2*XDIAG/3]
- jambe_gauche: dv in [YDIAG/12, YDIAG/6], du in [XDIAG/3, 2*XDIAG/3]
- tete: dv in [-YDIAG/4, YDIAG/4], du in [-XDIAG/2, XDIAG/3]
- museau: dv in [YDIAG/4, 2*YDIAG/3], du in [-XDIAG/4, XDIAG/3]
REQ-028 le_qbert SHALL be registered, reflecting x_cnt/y_cnt exactly 1 cycle later.

Reset
REQ-029 While reset=1: state SHALL be IDLE; the tick counter, qbert_x, qbert_y, latched endpoints and le_qbert SHALL be 0; busy and done SHALL be 0.
REQ-030 A reset asserted mid-hop SHALL abort the hop with no done pulse; IDLE tracking resumes on the first clk edge after release.

Configuration
REQ-031 With QBERT_FACING_EN defined, SHALL add output port facing (2 bits), latched at accept as {x1<x0, y1<y0}; facing[1] negates du and facing[0] negates dv before the zone tests; reset value 0.
REQ-032 Without QBERT_FACING_EN, SHALL have no facing port, and the zones SHALL use du and dv unmodified.

Verification (TICK_LOG2=2, STEP=1)
REQ-033 Reset mid-hop -> busy=0, done never pulses, qbert_x/y follow x0/y0 after release.
REQ-034 Hop (100,50)->(103,52) -> y moves first: 2 y steps, then 3 x steps, 4 cycles apart; done once; final position (103,52).
REQ-035 Hop (100,50)->(97,50) -> x moves to 97 in 3 ticks; y unchanged; done once.
REQ-036 STEP=4, hop x 100->106 -> x sequence 104, 106 with no overshoot.
REQ-037 Second qbert_jump while busy, and one during LAND -> both ignored; exactly one done pulse.
REQ-038 qbert at (200,300), x_cnt=235, y_cnt=330 -> le_qbert=6'b100000 one cycle later; with QBERT_FACING_EN and facing=2'b01, y_cnt=270 -> 6'b100000.

Source files
------------

// File: rtl/qbert_hop_engine.sv
// rtl/qbert_hop_engine.sv - Q*bert hop sequencer: tick-paced two-axis move plus sprite zone hit map
// Optional build macro: QBERT_FACING_EN adds the facing output and mirrors the zone tests.
module qbert_hop_engine #(
  parameter int XW        = 11,
  parameter int YW        = 10,
  parameter int STEP      = 1,
  parameter int TICK_LOG2 = 20,
  parameter int XDIAG     = 60,
  parameter int YDIAG     = 100
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  input  logic [XW-1:0] x_cnt,
  input  logic [YW-1:0] y_cnt,
  input  logic          qbert_jump,
  output logic [XW-1:0] qbert_x,
  output logic [YW-1:0] qbert_y,
  output logic          busy,
  output logic          done,
  output logic [5:0]    le_qbert
`ifdef QBERT_FACING_EN
  ,
  output logic [1:0]    facing
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_AXIS1, S_AXIS2, S_LAND} state_t;

  localparam logic signed [XW:0] STEP_X = (XW+1)'(STEP);
  localparam logic signed [YW:0] STEP_Y = (YW+1)'(STEP);

  localparam int X_2  = XDIAG / 2;
  localparam int X_3  = XDIAG / 3;
  localparam int X_4  = XDIAG / 4;
  localparam int X_23 = 2 * XDIAG / 3;
  localparam int Y_2  = YDIAG / 2;
  localparam int Y_4  = YDIAG / 4;
  localparam int Y_6  = YDIAG / 6;
  localparam int Y_12 = YDIAG / 12;
  localparam int Y_23 = 2 * YDIAG / 3;

  state_t               state, state_n;
  logic [TICK_LOG2-1:0] tick_cnt;
  logic                 tick;
  logic [XW-1:0]        x0_l, x1_l, qx_n;
  logic [YW-1:0]        y1_l, qy_n;
  logic signed [XW:0]   dx, adx, sx;
  logic signed [YW:0]   dy, ady, sy;
  logic                 y_first, move_y, at_target, accept;
  logic signed [XW:0]   du;
  logic signed [YW:0]   dv;
  int                   u, v;
  logic [5:0]           zone;

`ifdef QBERT_FACING_EN
  logic [YW-1:0]        y0_l;
  assign facing = {x1_l < x0_l, y1_l < y0_l};
`endif

  assign busy = (state != S_IDLE);
  assign done = (state == S_LAND);

  // Distances are one bit wider than the coordinates so no input pair can wrap.
  always_comb begin
    tick      = &tick_cnt;
    dx        = $signed({1'b0, x1_l}) - $signed({1'b0, qbert_x});
    dy        = $signed({1'b0, y1_l}) - $signed({1'b0, qbert_y});
    adx       = dx[XW] ? -dx : dx;
    ady       = dy[YW] ? -dy : dy;
    sx        = (adx > STEP_X) ? STEP_X : adx;
    sy        = (ady > STEP_Y) ? STEP_Y : ady;
    y_first   = x1_l > x0_l;
    move_y    = (state == S_AXIS1) ? y_first : !y_first;
    at_target = move_y ? (dy == '0) : (dx == '0);
    state_n   = state;
    qx_n      = qbert_x;
    qy_n      = qbert_y;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        qx_n = x0;
        qy_n = y0;
        if (qbert_jump) begin
          accept  = 1'b1;
          state_n = S_AXIS1;
        end
      end
      S_AXIS1, S_AXIS2: begin
        if (at_target) begin
          state_n = (state == S_AXIS1) ? S_AXIS2 : S_LAND;
        end else if (tick) begin
          if (move_y) qy_n = dy[YW] ? qbert_y - sy[YW-1:0] : qbert_y + sy[YW-1:0];
          else        qx_n = dx[XW] ? qbert_x - sx[XW-1:0] : qbert_x + sx[XW-1:0];
        end
      end
      S_LAND:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    du = $signed({1'b0, x_cnt}) - $signed({1'b0, qbert_x});
    dv = $signed({1'b0, y_cnt}) - $signed({1'b0, qbert_y});
    u  = int'(du);
    v  = int'(dv);
`ifdef QBERT_FACING_EN
    if (facing[1]) u = -u;
    if (facing[0]) v = -v;
`endif
    zone[5] = (v >= Y_6)   && (v <= Y_2)   && (u >= X_2)  && (u <= X_23);
    zone[4] = (v >= Y_12)  && (v <= Y_6)   && (u >= X_3)  && (u <= X_23);
    zone[3] = (v >= -Y_6)  && (v < Y_6)    && (u >= X_2)  && (u <= X_23);
    zone[2] = (v >= -Y_6)  && (v <= -Y_12) && (u >= X_3)  && (u <= X_23);
    zone[1] = (v >= -Y_4)  && (v <= Y_4)   && (u >= -X_2) && (u <= X_3);
    zone[0] = (v >= Y_4)   && (v <= Y_23)  && (u >= -X_4) && (u <= X_3);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      qbert_x  <= '0;
      qbert_y  <= '0;
      x0_l     <= '0;
      x1_l     <= '0;
      y1_l     <= '0;
`ifdef QBERT_FACING_EN
      y0_l     <= '0;
`endif
      le_qbert <= '0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt + TICK_LOG2'(1);
      qbert_x  <= qx_n;
      qbert_y  <= qy_n;
      le_qbert <= zone;
      if (accept) begin
        x0_l <= x0;
        x1_l <= x1;
        y1_l <= y1;
`ifdef QBERT_FACING_EN
        y0_l <= y0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_qbert_hop_engine.sv
// tb/tb_qbert_hop_engine.sv - directed bench for qbert_hop_engine: zone table plus hop sequences
module tb_qbert_hop_engine;
  localparam int XW = 11;
  localparam int YW = 10;
  localparam int NZ = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [XW-1:0] x0 = '0, x1 = '0, x_cnt = '0;
  logic [YW-1:0] y0 = '0, y1 = '0, y_cnt = '0;
  logic          qbert_jump = 1'b0;
  logic [XW-1:0] qx_a, qx_b;
  logic [YW-1:0] qy_a, qy_b;
  logic          busy_a, busy_b, done_a, done_b;
  logic [5:0]    le_a, le_b;
`ifdef QBERT_FACING_EN
  logic [1:0]    facing_a, facing_b;
`endif

  qbert_hop_engine #(.XW(XW), .YW(YW), .STEP(1), .TICK_LOG2(2)) dut (
    .clk(clk), .reset(reset), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .qbert_jump(qbert_jump),
    .qbert_x(qx_a), .qbert_y(qy_a), .busy(busy_a), .done(done_a), .le_qbert(le_a)
`ifdef QBERT_FACING_EN
    , .facing(facing_a)
`endif
  );

  qbert_hop_engine #(.XW(XW), .YW(YW), .STEP(4), .TICK_LOG2(2)) dut4 (
    .clk(clk), .reset(reset), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .qbert_jump(qbert_jump),
    .qbert_x(qx_b), .qbert_y(qy_b), .busy(busy_b), .done(done_b), .le_qbert(le_b)
`ifdef QBERT_FACING_EN
    , .facing(facing_b)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int xc; int yc; int qx; int qy; logic [5:0] le; } zv_t;
  typedef struct { bit is_y; int val; int cyc; } ev_t;

  zv_t zt[NZ];
  ev_t evq[$];
  int  n_cmp = 0, n_err = 0;
  int  done_cnt, done_cyc, fin_x, fin_y, busy_after;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int cur_x(input bit b);
    return b ? int'(qx_b) : int'(qx_a);
  endfunction

  function automatic int cur_y(input bit b);
    return b ? int'(qy_b) : int'(qy_a);
  endfunction

  // Launch one hop and log every position change up to the done cycle.
  task automatic run_hop(input bit use4, input int sx, input int sy, input int tx, input int ty,
                         input int glitch_cyc, input bit land_jump);
    int px, py, cx, cy;
    bit cd, cb;
    evq.delete();
    done_cnt = 0; done_cyc = -1; fin_x = -1; fin_y = -1; busy_after = 1;
    x0 = XW'(sx); y0 = YW'(sy); x1 = XW'(tx); y1 = YW'(ty);
    step(); step();
    px = sx; py = sy;
    qbert_jump = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      step();
      qbert_jump = 1'b0;
      cx = cur_x(use4); cy = cur_y(use4);
      cd = use4 ? done_b : done_a;
      cb = use4 ? busy_b : busy_a;
      if (done_cyc >= 0 && c == done_cyc + 1) busy_after = int'(cb);
      if (done_cyc < 0) begin
        if (cy != py) evq.push_back('{1'b1, cy, c});
        if (cx != px) evq.push_back('{1'b0, cx, c});
      end
      if (cd) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; fin_x = cx; fin_y = cy; end
      end
      px = cx; py = cy;
      if (c == glitch_cyc) begin qbert_jump = 1'b1; x1 = '0; end
      if (land_jump && cd) qbert_jump = 1'b1;
    end
    qbert_jump = 1'b0;
  endtask

  task automatic check_events(input string tag, input int n, input int e_y[6], input int e_v[6]);
    check({tag, " event count"}, evq.size(), n);
    for (int i = 0; i < n && i < evq.size(); i++) begin
      check($sformatf("%s ev%0d axis", tag, i), int'(evq[i].is_y), e_y[i]);
      check($sformatf("%s ev%0d value", tag, i), evq[i].val, e_v[i]);
      if (i > 0 && evq[i].is_y == evq[i-1].is_y)
        check($sformatf("%s ev%0d gap", tag, i), evq[i].cyc - evq[i-1].cyc, 4);
    end
  endtask

  initial begin
    int dsum, bsum;
    zt[0]  = '{235, 330,  200, 300, 6'h20};
    zt[1]  = '{235, 300,  200, 300, 6'h08};
    zt[2]  = '{225, 310,  200, 300, 6'h10};
    zt[3]  = '{225, 290,  200, 300, 6'h04};
    zt[4]  = '{200, 300,  200, 300, 6'h02};
    zt[5]  = '{200, 340,  200, 300, 6'h01};
    zt[6]  = '{200, 325,  200, 300, 6'h03};
    zt[7]  = '{235, 316,  200, 300, 6'h30};
    zt[8]  = '{230, 284,  200, 300, 6'h0C};
    zt[9]  = '{170, 300,  200, 300, 6'h02};
    zt[10] = '{169, 300,  200, 300, 6'h00};
    zt[11] = '{0,   0,    200, 300, 6'h00};
    zt[12] = '{2047, 1000, 2040, 1000, 6'h02};
    zt[13] = '{10,  1000, 2040, 1000, 6'h00};

    step(); step();
    check("reset busy", int'(busy_a), 0);
    check("reset done", int'(done_a), 0);
    check("reset qbert_x", int'(qx_a), 0);
    check("reset qbert_y", int'(qy_a), 0);
    check("reset le_qbert", int'(le_a), 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < NZ; i++) begin
      x0 = XW'(zt[i].qx); y0 = YW'(zt[i].qy);
      x_cnt = XW'(zt[i].xc); y_cnt = YW'(zt[i].yc);
      step(); step();
      check($sformatf("zone vec%0d", i), int'(le_a), int'(zt[i].le));
    end

    x0 = 11'd200; y0 = 10'd300; x_cnt = 11'd235; y_cnt = 10'd330;
    step(); step();
    x_cnt = 11'd200; y_cnt = 10'd300;
    check("le hold before edge", int'(le_a), 32);
    step();
    check("le one cycle later", int'(le_a), 2);
    x_cnt = '0; y_cnt = '0;

    run_hop(1'b0, 100, 50, 103, 52, 6, 1'b0);
    check_events("hop +x+y", 5, '{1, 1, 0, 0, 0, 0}, '{51, 52, 101, 102, 103, 0});
    check("hop +x+y done count", done_cnt, 1);
    check("hop +x+y final x", fin_x, 103);
    check("hop +x+y final y", fin_y, 52);
    check("hop +x+y busy after land", busy_after, 0);

    run_hop(1'b0, 100, 50, 97, 50, 0, 1'b0);
    check_events("hop -x", 3, '{0, 0, 0, 0, 0, 0}, '{99, 98, 97, 0, 0, 0});
    check("hop -x done count", done_cnt, 1);
    check("hop -x final x", fin_x, 97);
    check("hop -x final y", fin_y, 50);

    run_hop(1'b1, 100, 50, 106, 50, 0, 1'b0);
    check_events("step4 hop", 2, '{0, 0, 0, 0, 0, 0}, '{104, 106, 0, 0, 0, 0});
    check("step4 done count", done_cnt, 1);
    check("step4 final x", fin_x, 106);

    run_hop(1'b0, 100, 50, 100, 50, 0, 1'b1);
    check("null hop done cycle", done_cyc, 3);
    check("null hop done count", done_cnt, 1);
    check("null hop busy after land", busy_after, 0);

    x0 = 11'd100; y0 = 10'd50; x1 = 11'd103; y1 = 10'd52;
    step();
    qbert_jump = 1'b1;
    step();
    qbert_jump = 1'b0;
    repeat (6) step();
    check("midhop busy before reset", int'(busy_a), 1);
    reset = 1'b1; x0 = 11'd40; y0 = 10'd20;
    #1;
    check("async reset busy", int'(busy_a), 0);
    check("async reset qbert_x", int'(qx_a), 0);
    step();
    reset = 1'b0;
    step();
    check("post reset track x", int'(qx_a), 40);
    check("post reset track y", int'(qy_a), 20);
    dsum = 0; bsum = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      dsum += int'(done_a);
      bsum += int'(busy_a);
    end
    check("post reset done pulses", dsum, 0);
    check("post reset busy cycles", bsum, 0);

`ifdef QBERT_FACING_EN
    run_hop(1'b0, 200, 300, 200, 290, 0, 1'b0);
    check("facing latched", int'(facing_a), 1);
    x_cnt = 11'd235; y_cnt = 10'd270;
    step(); step();
    check("facing mirrored zone", int'(le_a), 32);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
